// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters.
// One operation in flight: grant in IDLE, compute in EXEC, hold the response in RESP.

package alu_opcodes_pkg;
    localparam logic [3:0] OP_ALU_ADD  = 4'h0;
    localparam logic [3:0] OP_ALU_SUB  = 4'h1;
    localparam logic [3:0] OP_ALU_AND  = 4'h2;
    localparam logic [3:0] OP_ALU_OR   = 4'h3;
    localparam logic [3:0] OP_ALU_XOR  = 4'h4;
    localparam logic [3:0] OP_ALU_SLL  = 4'h5;
    localparam logic [3:0] OP_ALU_SRL  = 4'h6;
    localparam logic [3:0] OP_ALU_SRA  = 4'h7;
    localparam logic [3:0] OP_ALU_SLT  = 4'h8;
    localparam logic [3:0] OP_ALU_SLTU = 4'h9;
endpackage

module alu #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result
);
    import alu_opcodes_pkg::*;

    localparam int SW = $clog2(WIDTH);

    logic [SW-1:0] w_shamt;
    assign w_shamt = i_b[SW-1:0];

    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ALU_ADD:  o_result = i_a + i_b;
            OP_ALU_SUB:  o_result = i_a - i_b;
            OP_ALU_AND:  o_result = i_a & i_b;
            OP_ALU_OR:   o_result = i_a | i_b;
            OP_ALU_XOR:  o_result = i_a ^ i_b;
            OP_ALU_SLL:  o_result = i_a << w_shamt;
            OP_ALU_SRL:  o_result = i_a >> w_shamt;
            OP_ALU_SRA:  o_result = $signed(i_a) >>> w_shamt;
            OP_ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            OP_ALU_SLTU: o_result = {{(WIDTH-1){1'b0}}, i_a < i_b};
            default:     o_result = '0;
        endcase
    end
endmodule

// state | meaning
// IDLE  | searching for a winner from rr_ptr, grant is combinational
// EXEC  | captured operands feed the ALU, result registered at the edge
// RESP  | response held to the owner until its rsp_ready (or flush)
module alu_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic [4*NUM_REQ-1:0]     i_req_op,
    input  logic [WIDTH*NUM_REQ-1:0] i_req_a,
    input  logic [WIDTH*NUM_REQ-1:0] i_req_b,
    output logic [NUM_REQ-1:0]       o_rsp_valid,
    input  logic [NUM_REQ-1:0]       i_rsp_ready,
    output logic [WIDTH-1:0]         o_rsp_result,
    output logic                     o_busy
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t             r_state;
    logic [PW-1:0]      r_rr_ptr;
    logic [PW-1:0]      r_owner;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_result;
    logic [NUM_REQ-1:0] r_rsp_valid;

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [PW-1:0]        w_off;
    logic                 w_found;
    logic [PW:0]          w_sum;
    logic [PW-1:0]        w_winner;
    logic [NUM_REQ-1:0]   w_grant;
    logic [3:0]           w_op;
    logic [WIDTH-1:0]     w_a;
    logic [WIDTH-1:0]     w_b;
    logic [WIDTH-1:0]     w_alu_result;
    logic [PW-1:0]        w_next_ptr;

    // Rotate valids so bit 0 is the requester at rr_ptr; the lowest set bit wins.
    assign w_dbl = {i_req_valid, i_req_valid} >> r_rr_ptr;
    assign w_rot = w_dbl[NUM_REQ-1:0];

    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_found = 1'b1;
                w_off   = PW'(j);
            end
        end
    end

    assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_off};
    assign w_winner = (w_sum >= (PW+1)'(NUM_REQ)) ? PW'(w_sum - (PW+1)'(NUM_REQ))
                                                   : w_sum[PW-1:0];
    assign w_next_ptr = (w_winner == PW'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;

    assign w_grant = (r_state == S_IDLE && !i_flush && i_rst_n && w_found)
                     ? (NUM_REQ'(1) << w_winner) : '0;

    always_comb begin
        w_op = '0;
        w_a  = '0;
        w_b  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_winner == PW'(k)) begin
                w_op = i_req_op[4*k +: 4];
                w_a  = i_req_a[WIDTH*k +: WIDTH];
                w_b  = i_req_b[WIDTH*k +: WIDTH];
            end
        end
    end

    alu #(.WIDTH(WIDTH)) u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_rsp_valid <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_grant) begin
                        r_op     <= w_op;
                        r_a      <= w_a;
                        r_b      <= w_b;
                        r_owner  <= w_winner;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result    <= w_alu_result;
                        r_rsp_valid <= NUM_REQ'(1) << r_owner;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Flush takes priority over a simultaneous rsp_ready.
                    if (i_flush || i_rsp_ready[r_owner]) begin
                        r_rsp_valid <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= '0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready  = w_grant;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_result = r_result;
    assign o_busy       = (r_state != S_IDLE);
endmodule
